// File: rtl/interp_sample_ctrl.sv
// Sample-rate controller for the interpolating filter chain: integer clock-enable
// divider, small sample FIFO and an IDLE/PRIME/RUN/STOP sequencer feeding the filter.
module interp_sample_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DIV_W       = 8,
    parameter int DEPTH       = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int FLUSH_LEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_ratio,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              filt_clk_enable,
    input  logic              filt_ce_out,
    output logic [DATA_W-1:0] filt_input_data,
    output logic [1:0]        state,
    output logic              running,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] PRIME_LVL  = CW'(PRIME_LEVEL);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_lat_q;
    logic              ce_q, ce_d;
    logic [FW-1:0]     flush_cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              underrun_q;
    logic [15:0]       ucnt_q;
    logic              active_q, active_d, div_hit;
    logic              consume, push, pop, starve, fifo_clear;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PRIME;
            ST_PRIME: begin
                if (!enable)                   state_d = ST_IDLE;
                else if (count_q >= PRIME_LVL) state_d = ST_RUN;
            end
            ST_RUN:   if (!enable) state_d = ST_STOP;
            ST_STOP:  if (ce_q && flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Enables are only issued while both this and next cycle are RUN/STOP, so
    // the pulse that would follow the last flush pulse never leaks into IDLE.
    assign active_q   = (state_q == ST_RUN) || (state_q == ST_STOP);
    assign active_d   = (state_d == ST_RUN) || (state_d == ST_STOP);
    assign div_hit    = (div_cnt_q == div_lat_q);
    assign div_cnt_d  = (active_q && !div_hit) ? div_cnt_q + DIV_W'(1) : '0;
    assign ce_d       = active_q && active_d && div_hit;

    assign consume    = ce_q && filt_ce_out && active_q;
    assign s_ready    = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && (count_q < FULL_LVL);
    assign push       = s_valid && s_ready;
    assign pop        = consume && (state_q == ST_RUN) && (count_q != '0);
    assign starve     = consume && (state_q == ST_RUN) && (count_q == '0);
    assign fifo_clear = (state_q == ST_IDLE) || (state_q == ST_STOP);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            div_lat_q   <= '0;
            ce_q        <= 1'b0;
            flush_cnt_q <= '0;
            data_q      <= '0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            ce_q      <= ce_d;
            if (state_q == ST_PRIME && state_d == ST_RUN) div_lat_q <= div_ratio;
            flush_cnt_q <= (state_q == ST_STOP) ? flush_cnt_q + FW'(ce_q) : '0;
            if (state_q == ST_IDLE)  data_q <= '0;
            else if (consume)        data_q <= pop ? mem_q[rd_ptr_q] : '0;
            underrun_q <= starve;
            if (starve && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign filt_clk_enable = ce_q;
    assign filt_input_data = data_q;
    assign state           = state_q;
    assign running         = (state_q == ST_RUN);
    assign underrun        = underrun_q;
    assign underrun_cnt    = ucnt_q;
endmodule

// File: tb/tb_interp_sample_ctrl.sv
// Directed bench for interp_sample_ctrl: reset, start-up, divider, FIFO order,
// underrun saturation, stop flush and divider re-latching.
module tb_interp_sample_ctrl;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  div_ratio;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        filt_clk_enable;
    logic        filt_ce_out;
    logic [15:0] filt_input_data;
    logic [1:0]  state;
    logic        running;
    logic        underrun;
    logic [15:0] underrun_cnt;

    logic ce_force;
    logic tie_ce;
    int   n_cmp;
    int   n_bad;

    assign filt_ce_out = ce_force | (tie_ce & filt_clk_enable);

    interp_sample_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .div_ratio(div_ratio),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .filt_clk_enable(filt_clk_enable), .filt_ce_out(filt_ce_out),
        .filt_input_data(filt_input_data), .state(state), .running(running),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        div_ratio = '0; ce_force = 1'b0; tie_ce = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic prime(input logic [7:0] div, input logic [15:0] a, input logic [15:0] b);
        enable = 1'b1; div_ratio = div;
        step();
        s_valid = 1'b1; s_data = a;
        step();
        s_data = b;
        step();
        s_valid = 1'b0;
        step();
    endtask

    task automatic measure_gap(output int gap, output bit ok);
        int n;
        ok = 1'b0; gap = 0; n = 0;
        while (filt_clk_enable !== 1'b1 && n < 40) begin step(); n++; end
        if (filt_clk_enable === 1'b1) begin
            step(); gap = 1;
            while (filt_clk_enable !== 1'b1 && gap < 40) begin step(); gap++; end
            ok = (filt_clk_enable === 1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (filt_clk_enable !== 1'b0) begin n_bad++; $display("FAIL reset_ce: got %b want 0", filt_clk_enable); end
        n_cmp++; if (filt_input_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", filt_input_data); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_cmp++; if (underrun_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_ucnt: got %h want 0000", underrun_cnt); end
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        do_reset();
        tie_ce = 1'b1;
        prime(8'd3, 16'h0AAA, 16'h0BBB);
        repeat (4) step();
        step();
        repeat (3) step();
        n_cmp++; if (filt_clk_enable !== 1'b1) begin n_bad++; $display("FAIL midrun_pre_ce: got %b want 1", filt_clk_enable); end
        n_cmp++; if (filt_input_data !== 16'h0AAA) begin n_bad++; $display("FAIL midrun_pre_data: got %h want 0aaa", filt_input_data); end
        reset = 1'b1; enable = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL midrun_state: got %0d want 0", state); end
        n_cmp++; if (filt_clk_enable !== 1'b0) begin n_bad++; $display("FAIL midrun_ce: got %b want 0", filt_clk_enable); end
        n_cmp++; if (filt_input_data !== 16'h0) begin n_bad++; $display("FAIL midrun_data: got %h want 0000", filt_input_data); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL midrun_running: got %b want 0", running); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL midrun_s_ready: got %b want 0", s_ready); end
        step();
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (state !== 2'd0 || filt_clk_enable !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL midrun_after: got activity want idle"); end
    endtask

    task automatic test_start_starve();
        bit bad;
        do_reset();
        ce_force = 1'b1;
        enable = 1'b1; div_ratio = 8'd3;
        step();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_prime: got %0d want 1", state); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL start_s_ready: got %b want 1", s_ready); end
        s_valid = 1'b1; s_data = 16'h1234;
        step();
        s_data = 16'h0042;
        step();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_still_prime: got %0d want 1", state); end
        s_valid = 1'b0;
        step();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL start_run: got %0d want 2", state); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", running); end
        bad = 1'b0;
        repeat (3) begin
            step();
            if (filt_clk_enable !== 1'b0 || filt_input_data !== 16'h0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL start_early: got enable/data before cycle 4 want none"); end
        step();
        n_cmp++; if (filt_clk_enable !== 1'b1) begin n_bad++; $display("FAIL start_first_ce: got %b want 1", filt_clk_enable); end
        step();
        n_cmp++; if (filt_input_data !== 16'h1234) begin n_bad++; $display("FAIL start_data0: got %h want 1234", filt_input_data); end
        repeat (3) step();
        n_cmp++; if (filt_clk_enable !== 1'b1) begin n_bad++; $display("FAIL start_second_ce: got %b want 1", filt_clk_enable); end
        n_cmp++; if (filt_input_data !== 16'h1234) begin n_bad++; $display("FAIL start_hold: got %h want 1234", filt_input_data); end
        step();
        n_cmp++; if (filt_input_data !== 16'h0042) begin n_bad++; $display("FAIL start_data1: got %h want 0042", filt_input_data); end
        repeat (4) step();
        n_cmp++; if (filt_input_data !== 16'h0) begin n_bad++; $display("FAIL starve_data: got %h want 0000", filt_input_data); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL starve_pulse: got %b want 1", underrun); end
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_bad++; $display("FAIL starve_cnt: got %0d want 1", underrun_cnt); end
        step();
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL starve_pulse_end: got %b want 0", underrun); end
    endtask

    task automatic test_div0();
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        logic [15:0] pushed;
        logic        do_push, do_pop, was_empty;
        bit          ce_gap, seen_ce, bad_ur;
        int          pops;
        do_reset();
        tie_ce = 1'b1; div_ratio = 8'd0; enable = 1'b1;
        s_valid = 1'b1; s_data = 16'h8000;
        ce_gap = 1'b0; seen_ce = 1'b0; bad_ur = 1'b0; pops = 0;
        for (int i = 0; i < 30; i++) begin
            do_push = s_valid && s_ready;
            do_pop  = filt_clk_enable && (state == 2'd2);
            pushed  = s_data;
            step();
            if (do_pop) begin
                pops++;
                was_empty = (exp_q.size() == 0);
                if (was_empty) exp_v = '0;
                else exp_v = exp_q.pop_front();
                n_cmp++;
                if (filt_input_data !== exp_v) begin
                    n_bad++; $display("FAIL div0_data: got %h want %h", filt_input_data, exp_v);
                end
                if (underrun !== was_empty) bad_ur = 1'b1;
            end else if (underrun !== 1'b0) begin
                bad_ur = 1'b1;
            end
            if (do_push) exp_q.push_back(pushed);
            if (filt_clk_enable === 1'b1) seen_ce = 1'b1;
            else if (seen_ce) ce_gap = 1'b1;
            s_data = s_data + 16'h0101;
        end
        n_cmp++; if (pops !== 25) begin n_bad++; $display("FAIL div0_pops: got %0d want 25", pops); end
        n_cmp++; if (ce_gap) begin n_bad++; $display("FAIL div0_every_cycle: got gap want continuous"); end
        n_cmp++; if (bad_ur) begin n_bad++; $display("FAIL div0_underrun: got pulse want none"); end
        n_cmp++; if (underrun_cnt !== 16'd0) begin n_bad++; $display("FAIL div0_ucnt: got %0d want 0", underrun_cnt); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL div0_level: got s_ready %b want 1", s_ready); end
        s_valid = 1'b0;
    endtask

    task automatic test_stop();
        int pulses, n;
        bit bad_state, bad_data, bad_ready;
        do_reset();
        tie_ce = 1'b1; enable = 1'b1; div_ratio = 8'd3;
        step();
        s_valid = 1'b1; s_data = 16'h1111;
        step();
        s_data = 16'h2222;
        step();
        s_data = 16'h3333;
        step();
        s_valid = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL stop_run: got %0d want 2", state); end
        repeat (5) step();
        n_cmp++; if (filt_input_data !== 16'h1111) begin n_bad++; $display("FAIL stop_pre_data: got %h want 1111", filt_input_data); end
        enable = 1'b0;
        step();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL stop_state: got %0d want 3", state); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL stop_s_ready: got %b want 0", s_ready); end
        pulses = 0; n = 0; bad_state = 1'b0; bad_data = 1'b0; bad_ready = 1'b0;
        while (pulses < 64 && n < 400) begin
            step(); n++;
            if (pulses > 0 && filt_input_data !== 16'h0) bad_data = 1'b1;
            if (s_ready !== 1'b0) bad_ready = 1'b1;
            if (state !== 2'd3) bad_state = 1'b1;
            if (filt_clk_enable === 1'b1) pulses++;
            if (pulses == 10) enable = 1'b1;
        end
        n_cmp++; if (pulses !== 64) begin n_bad++; $display("FAIL stop_pulses: got %0d want 64", pulses); end
        n_cmp++; if (bad_state) begin n_bad++; $display("FAIL stop_held: got early exit want STOP"); end
        n_cmp++; if (bad_data) begin n_bad++; $display("FAIL stop_zero: got nonzero data want 0000"); end
        n_cmp++; if (bad_ready) begin n_bad++; $display("FAIL stop_ready: got 1 want 0"); end
        step();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL stop_idle: got %0d want 0", state); end
        n_cmp++; if (filt_clk_enable !== 1'b0) begin n_bad++; $display("FAIL stop_idle_ce: got %b want 0", filt_clk_enable); end
        step();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL stop_reprime: got %0d want 1", state); end
        s_valid = 1'b1; s_data = 16'h5555;
        step();
        s_valid = 1'b0;
        step(); step();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL stop_fifo_flushed: got %0d want 1", state); end
        enable = 1'b0;
    endtask

    task automatic test_div_change();
        int gap, n;
        bit ok;
        do_reset();
        tie_ce = 1'b1;
        prime(8'd3, 16'h0101, 16'h0202);
        div_ratio = 8'd7;
        measure_gap(gap, ok);
        n_cmp++; if (!ok || gap !== 4) begin n_bad++; $display("FAIL divchg_gap1: got %0d want 4", gap); end
        measure_gap(gap, ok);
        n_cmp++; if (!ok || gap !== 4) begin n_bad++; $display("FAIL divchg_gap2: got %0d want 4", gap); end
        enable = 1'b0;
        n = 0;
        while (state !== 2'd0 && n < 400) begin step(); n++; end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL divchg_idle: got %0d want 0", state); end
        prime(8'd7, 16'h0303, 16'h0404);
        measure_gap(gap, ok);
        n_cmp++; if (!ok || gap !== 8) begin n_bad++; $display("FAIL divchg_relatch: got %0d want 8", gap); end
    endtask

    task automatic test_underrun_sat();
        do_reset();
        tie_ce = 1'b1;
        prime(8'd0, 16'h7FFF, 16'h8001);
        step(); step();
        n_cmp++; if (filt_input_data !== 16'h7FFF) begin n_bad++; $display("FAIL sat_data0: got %h want 7fff", filt_input_data); end
        step();
        n_cmp++; if (filt_input_data !== 16'h8001) begin n_bad++; $display("FAIL sat_data1: got %h want 8001", filt_input_data); end
        step();
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_bad++; $display("FAIL sat_first: got %0d want 1", underrun_cnt); end
        for (int k = 5; k <= 70003; k++) begin
            step();
            if (k == 1003) begin
                n_cmp++;
                if (underrun_cnt !== 16'd1000) begin n_bad++; $display("FAIL sat_mid: got %0d want 1000", underrun_cnt); end
            end
        end
        n_cmp++; if (underrun_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_final: got %h want ffff", underrun_cnt); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL sat_pulse: got %b want 1", underrun); end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL sat_state: got %0d want 2", state); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; enable = 1'b0; div_ratio = '0; s_valid = 1'b0; s_data = '0;
        ce_force = 1'b0; tie_ce = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_start_starve();
        test_div0();
        test_stop();
        test_div_change();
        test_underrun_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/interp_sample_ctrl.md
# interp_sample_ctrl

Sample-rate controller and feeder for the 16-bit interpolating filter chain in the sigma-delta DAC path. It derives the filter's base clock-enable from a programmable integer divider and buffers upstream PCM samples in a small FIFO. Each sample is presented to the filter input when the chain signals consumption. It sequences start-up (prime), steady run, underrun substitution and a zero-input flush on stop, so the filter never sees stale or partial data.

## Interface
- DATA_W, 16, sample width; matches filter `input_data`.
- DIV_W, 8, width of `div_ratio`.
- DEPTH, 4, FIFO depth in samples; power of two, ≥2.
- PRIME_LEVEL, 2, FIFO occupancy required to leave PRIME; 1..DEPTH.
- FLUSH_LEN, 64, number of `filt_clk_enable` pulses issued in STOP before IDLE.

- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs to reset values immediately.
- enable  in  1  run request, level-sensitive.
- div_ratio  in  DIV_W  base enable period minus 1; latched on PRIME→RUN.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept; transfer when `s_valid && s_ready`.
- s_data  in  DATA_W  upstream sample, signed.
- filt_clk_enable  out  1  to filter `clk_enable`; single-cycle pulses.
- filt_ce_out  in  1  filter sample-consume strobe (its `ce_out`).
- filt_input_data  out  DATA_W  to filter `input_data`, signed, registered.
- state  out  2  IDLE=0, PRIME=1, RUN=2, STOP=3.
- running  out  1  high in RUN.
- underrun  out  1  one-cycle pulse per underrun event.
- underrun_cnt  out  16  saturating count of underruns.

## Operation
- IDLE: FIFO held empty, `s_ready`=0, no enables, `filt_input_data`=0. `enable`=1 → PRIME next cycle.
- PRIME: `s_ready` = (count<DEPTH). Divider stopped. count ≥ PRIME_LEVEL and `enable`=1 → RUN; latch `div_ratio`, clear divider. `enable`=0 in PRIME → IDLE.
- RUN: divider counts 0..div_ratio_latched; `filt_clk_enable`=1 in the cycle after the counter equals the latched ratio, counter wraps to 0. `div_ratio`=0 → enable every cycle. On `filt_clk_enable` with `filt_ce_out`: FIFO non-empty → pop head into `filt_input_data`. FIFO empty → `filt_input_data`←0, `underrun` pulse, `underrun_cnt`+1, saturating at 0xFFFF. `enable`=0 → STOP.
- STOP: `s_ready`=0; residual FIFO contents discarded. Divider keeps running. Every consume loads 0. Underruns are not counted. Flush counter counts issued `filt_clk_enable` pulses; after the FLUSH_LEN-th pulse → IDLE. `enable` is ignored until IDLE is reached; if it is still high there, PRIME follows on the next cycle.
- FIFO: push and pop in the same cycle leave count unchanged. Push when full is impossible because `s_ready`=0. Pop on empty is an underrun; a push in that same cycle is stored, not bypassed.
- `filt_ce_out` without a coincident `filt_clk_enable`, or outside RUN/STOP, is ignored.
- `underrun_cnt` is cleared only by `reset`.

## Timing
- Reset values: `s_ready`=0, `filt_clk_enable`=0, `filt_input_data`=0, `state`=IDLE, `running`=0, `underrun`=0, `underrun_cnt`=0.
- State transitions take effect on the clock after the condition.
- First `filt_clk_enable` occurs div_ratio+1 cycles after entering RUN; period thereafter is div_ratio+1.
- `filt_input_data` updates one cycle after the consume strobe and is held until the next consume.
- `s_ready` is combinational from state and count. A sample pushed at cycle t is poppable from t+1.
- Last STOP pulse at cycle t → `state`=IDLE at t+1. FIFO is empty at t+1.

## Test plan
- Reset mid-RUN (div_ratio=3, FIFO 3 deep) → all outputs at reset values in the same cycle. `state`=0 and no enables afterwards.
- Start: push 0x1234, 0x0042; enable=1, div_ratio=3, PRIME_LEVEL=2 → RUN after 2nd push. Enables every 4 cycles. With filt_ce_out tied to filt_clk_enable, `filt_input_data` = 0x1234, then 0x0042.
- div_ratio=0 with continuous s_valid → `filt_clk_enable` every cycle. Push and pop coincide, count stays constant, no underrun.
- Starve in RUN: stop s_valid, 2 samples left → 3rd consume gives `filt_input_data`=0, `underrun` pulse, `underrun_cnt`=1. Drive 70000 underruns → `underrun_cnt`=0xFFFF.
- Stop: enable=0 in RUN with 2 samples buffered, FLUSH_LEN=64 → `s_ready`=0, 64 enables with input 0, then IDLE. Re-asserting enable mid-STOP has no effect until IDLE, then PRIME.
- `div_ratio` changed from 3 to 7 mid-RUN → period stays 4 until the next PRIME→RUN.
